id_ex_stage: RTL and testbench



---
 rtl/core_pkg.sv | 21 ++
 rtl/operand_mux.sv | 24 ++
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and EX-register layout for the 5-stage integer core.
package core_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b10;
   localparam logic [1:0] FWD_MEM = 2'b01;

   typedef struct packed {
      logic             valid;
      logic             wren;
      logic             is_load;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  op_a;
      logic [XLEN-1:0]  op_b;
      logic [XLEN-1:0]  store_data;
   } id_ex_t;

endpackage

// File: rtl/operand_mux.sv
// Forwarding operand select: regfile, EX result or MEM result by 2-bit code.
module operand_mux
   import core_pkg::*;
#(
   parameter int unsigned W = core_pkg::XLEN
) (
   input  logic [1:0]   code,
   input  logic [W-1:0] rf_data,
   input  logic [W-1:0] ex_data,
   input  logic [W-1:0] mem_data,
   output logic [W-1:0] sel
);

   // The illegal code 11 falls to the EX value: the youngest producer wins.
   always_comb begin
      sel = ex_data;
      case (code)
         FWD_RF:  sel = rf_data;
         FWD_MEM: sel = mem_data;
         default: sel = ex_data;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Optional load-use stall counter output enabled by `define ID_EX_STALL_CNT_EN.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int unsigned XLEN  = core_pkg::XLEN,
   parameter int unsigned REG_W = core_pkg::REG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_wren,
   input  logic             id_is_load,
   input  logic             id_alu_src_imm,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [XLEN-1:0]  rf_rs1_data,
   input  logic [XLEN-1:0]  rf_rs2_data,
   input  logic [1:0]       fwd_a,
   input  logic [1:0]       fwd_b,
   input  logic [XLEN-1:0]  ex_fwd_data,
   input  logic [XLEN-1:0]  mem_fwd_data,
   input  logic             flush,
   input  logic             hold,
   output logic             stall_id,
   output logic             ex_valid,
   output logic             ex_wren,
   output logic             ex_is_load,
   output logic [REG_W-1:0] ex_rd,
   output logic [XLEN-1:0]  ex_op_a,
   output logic [XLEN-1:0]  ex_op_b,
   output logic [XLEN-1:0]  ex_store_data
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0]      lu_stall_count
`endif
);

   id_ex_t          r;
   id_ex_t          r_nxt;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            lu;
   logic            lu_bubble;

   operand_mux #(.W(XLEN)) u_mux_a (
      .code     (fwd_a),
      .rf_data  (rf_rs1_data),
      .ex_data  (ex_fwd_data),
      .mem_data (mem_fwd_data),
      .sel      (rs1_val)
   );

   operand_mux #(.W(XLEN)) u_mux_b (
      .code     (fwd_b),
      .rf_data  (rf_rs2_data),
      .ex_data  (ex_fwd_data),
      .mem_data (mem_fwd_data),
      .sel      (rs2_val)
   );

   always_comb begin
      lu = id_valid & r.valid & r.is_load & r.wren & (r.rd != '0) &
           ((id_use_rs1 & (r.rd == id_rs1)) | (id_use_rs2 & (r.rd == id_rs2)));
      stall_id  = (hold | lu) & ~flush;
      lu_bubble = lu & ~hold & ~flush;
   end

   always_comb begin
      r_nxt = r;
      if (flush) begin
         r_nxt = '0;
      end else if (hold) begin
         r_nxt = r;
      end else if (lu) begin
         r_nxt = '0;
      end else begin
         r_nxt.valid      = id_valid;
         r_nxt.wren       = id_wren & id_valid;
         r_nxt.is_load    = id_is_load;
         r_nxt.rd         = id_rd;
         r_nxt.op_a       = rs1_val;
         r_nxt.op_b       = id_alu_src_imm ? id_imm : rs2_val;
         r_nxt.store_data = rs2_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r <= '0;
      else        r <= r_nxt;
   end

   assign ex_valid      = r.valid;
   assign ex_wren       = r.wren;
   assign ex_is_load    = r.is_load;
   assign ex_rd         = r.rd;
   assign ex_op_a       = r.op_a;
   assign ex_op_b       = r.op_b;
   assign ex_store_data = r.store_data;

`ifdef ID_EX_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         lu_stall_count <= '0;
      else if (lu_bubble) lu_stall_count <= lu_stall_count + 32'd1;
   end
`else
   logic unused_lu_bubble;
   assign unused_lu_bubble = lu_bubble;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage (covers ID_EX_STALL_CNT_EN when defined).
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_use_rs1, id_use_rs2, id_wren, id_is_load, id_alu_src_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_imm, rf_rs1_data, rf_rs2_data, ex_fwd_data, mem_fwd_data;
   logic [1:0]  fwd_a, fwd_b;
   logic        flush, hold;
   logic        stall_id, ex_valid, ex_wren, ex_is_load;
   logic [4:0]  ex_rd;
   logic [31:0] ex_op_a, ex_op_b, ex_store_data;
`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] lu_stall_count;
`endif

   typedef struct packed {
      logic        valid;
      logic        wren;
      logic        is_load;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
   } exp_t;

   exp_t        m;
   exp_t        sb[$];
   int unsigned m_cnt;
   int          n_cmp = 0;
   int          n_err = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wren(id_wren),
      .id_is_load(id_is_load), .id_alu_src_imm(id_alu_src_imm), .id_imm(id_imm),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .flush(flush), .hold(hold),
      .stall_id(stall_id), .ex_valid(ex_valid), .ex_wren(ex_wren), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data)
`ifdef ID_EX_STALL_CNT_EN
      , .lu_stall_count(lu_stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] res(input logic [1:0] code, input logic [31:0] rf,
                                       input logic [31:0] ex, input logic [31:0] mem);
      if (code == 2'b00)      return rf;
      else if (code == 2'b01) return mem;
      else                    return ex;
   endfunction

   task automatic check_outputs(input exp_t e);
      check("ex_valid",      ex_valid,      e.valid);
      check("ex_wren",       ex_wren,       e.wren);
      check("ex_is_load",    ex_is_load,    e.is_load);
      check("ex_rd",         ex_rd,         e.rd);
      check("ex_op_a",       ex_op_a,       e.a);
      check("ex_op_b",       ex_op_b,       e.b);
      check("ex_store_data", ex_store_data, e.sd);
`ifdef ID_EX_STALL_CNT_EN
      check("lu_stall_count", lu_stall_count, m_cnt);
`endif
   endtask

   // Called at posedge+1 with inputs already driven; predicts, clocks, compares.
   task automatic cycle();
      exp_t        e;
      exp_t        got;
      logic        lu;
      logic [31:0] r2;
      #1;
      lu = id_valid && m.valid && m.is_load && m.wren && (m.rd != 5'd0) &&
           ((id_use_rs1 && m.rd == id_rs1) || (id_use_rs2 && m.rd == id_rs2));
      check("stall_id", stall_id, (hold || lu) && !flush);
      r2 = res(fwd_b, rf_rs2_data, ex_fwd_data, mem_fwd_data);
      if (flush)     e = '0;
      else if (hold) e = m;
      else if (lu)   e = '0;
      else begin
         e.valid   = id_valid;
         e.wren    = id_wren && id_valid;
         e.is_load = id_is_load;
         e.rd      = id_rd;
         e.a       = res(fwd_a, rf_rs1_data, ex_fwd_data, mem_fwd_data);
         e.b       = id_alu_src_imm ? id_imm : r2;
         e.sd      = r2;
      end
      if (lu && !hold && !flush) m_cnt++;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check_outputs(got);
      m = got;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic w, input logic ld);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = rd; id_wren = w; id_is_load = ld;
      id_alu_src_imm = 1'b0; id_imm = 32'h0; fwd_a = 2'b00; fwd_b = 2'b00;
      flush = 1'b0; hold = 1'b0;
   endtask

   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      #1;
      m = '0;
      m_cnt = 0;
      check_outputs(m);
      check("stall_id_rst", stall_id, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      m = '0;
      m_cnt = 0;
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      rf_rs1_data = 32'hAAAA; rf_rs2_data = 32'hBBBB;
      ex_fwd_data = 32'h11;   mem_fwd_data = 32'h22;
      #3;
      check_outputs(m);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Forward EX into A and MEM into B
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      fwd_a = 2'b10; fwd_b = 2'b01;
      cycle();
      check("tp1_op_a", ex_op_a, 32'h11);
      check("tp1_op_b", ex_op_b, 32'h22);

      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      cycle();

      // Load-use on rs1: one bubble, then retry takes the MEM value
      set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
      cycle();
      set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      mem_fwd_data = 32'h55;
      cycle();
      check("lu_bubble_valid", ex_valid, 1'b0);
      fwd_a = 2'b01;
      cycle();
      check("lu_retry_op_a", ex_op_a, 32'h55);

      // Load-use on rs2 only
      set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1);
      cycle();
      set_id(1'b1, 5'd1, 5'd8, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
      cycle();

      // Load to x0: no stall
      set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1);
      cycle();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      cycle();
      check("rd0_no_bubble", ex_valid, 1'b1);

      // Matching rs1 but not used: no stall
      set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
      cycle();
      set_id(1'b1, 5'd5, 5'd6, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
      cycle();
      check("unused_rs1_captured", ex_rd, 5'd3);

      // Hold stretches a load-use stall, then the bubble follows
      set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1);
      cycle();
      set_id(1'b1, 5'd6, 5'd1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
      hold = 1'b1;
      cycle();
      hold = 1'b0;
      cycle();
      cycle();

      // Hold for three cycles with changing ID, then flush beats hold
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
      ex_fwd_data = 32'h1234; fwd_a = 2'b10;
      cycle();
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 5'(i + 1), 5'(i + 2), 1'b1, 1'b1, 5'(20 + i), 1'b1, 1'b0);
         ex_fwd_data = 32'(i * 7 + 3); fwd_a = 2'b10; hold = 1'b1;
         cycle();
         check("hold_rd", ex_rd, 5'd12);
      end
      flush = 1'b1; hold = 1'b1;
      cycle();
      check("flush_hold_valid", ex_valid, 1'b0);

      // Illegal code 11 resolves to EX; immediate operand B
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
      ex_fwd_data = 32'hA; mem_fwd_data = 32'hB; rf_rs2_data = 32'h77;
      fwd_a = 2'b11; id_alu_src_imm = 1'b1; id_imm = 32'hFFFF_FFFC;
      cycle();
      check("fwd11_op_a", ex_op_a, 32'hA);
      check("imm_op_b", ex_op_b, 32'hFFFF_FFFC);
      check("imm_store", ex_store_data, 32'h77);

      // Invalid slot with wren set
      set_id(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
      cycle();

      // Asynchronous reset mid-stream with a valid instruction in EX
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b1);
      cycle();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      do_reset();

      // Four load-use bubbles
      for (int i = 0; i < 4; i++) begin
         set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
         cycle();
         set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
         cycle();
      end
`ifdef ID_EX_STALL_CNT_EN
      check("lu_count_4", lu_stall_count, 32'd4);
`endif
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
